// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the on-chip subordinates.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } sub_state_t;

endpackage

// File: rtl/ahb_byte_strobe_gen.sv
// Byte-lane strobe from HSIZE and address low bits; sizes above word select all lanes.
module ahb_byte_strobe_gen
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] strobe
);

  always_comb begin
    strobe = 4'b1111;
    case (hsize)
      HSIZE_BYTE: strobe = 4'b0001 << addr_lo;
      HSIZE_HALF: strobe = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    strobe = 4'b1111;
    endcase
  end

endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate in front of a word-organised SRAM with programmable wait states.
// Define AHB_SRAM_ERR_RESP_EN to return two-cycle ERROR for out-of-range addresses or HSIZE>2.
module ahb_sram_subordinate
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int          AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS = 4'(WAIT_STATES);

  logic [31:0]   mem [DEPTH_WORDS];
  sub_state_t    state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [AW-1:0] idx_q;
  logic [1:0]    ofs_q;
  logic [2:0]    size_q;
  logic          write_q;
  logic [31:0]   offset;
  logic          ready_state;
  logic          accept;
  logic          err_req;
  logic [3:0]    strobe;
  logic          unused_bits;

  assign offset      = HADDR - BASE_ADDR;
  assign ready_state = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
  assign accept      = HSEL && HREADY && HTRANS[1] && ready_state;

`ifdef AHB_SRAM_ERR_RESP_EN
  assign err_req     = (offset >= 32'(4 * DEPTH_WORDS)) || (HSIZE > 3'd2);
  assign unused_bits = ^{offset[1:0], HTRANS[0]};
`else
  // Without error responses the upper offset bits are dropped, so the index wraps.
  assign err_req     = 1'b0;
  assign unused_bits = ^{offset[31:AW+2], offset[1:0], HTRANS[0]};
`endif

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    HREADYOUT  = 1'b1;
    HRESP      = HRESP_OKAY;
    case (state_q)
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (wait_cnt_q == 4'd0) state_d = ST_DATA;
        else                    wait_cnt_d = wait_cnt_q - 4'd1;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase
    // A completing (or idle) data phase can overlap the next address phase.
    if (ready_state) begin
      state_d = ST_IDLE;
      if (accept) begin
        if (err_req) begin
          state_d = ST_ERR1;
        end else if (WS != 4'd0) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WS - 4'd1;
        end else begin
          state_d = ST_DATA;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      idx_q      <= '0;
      ofs_q      <= 2'd0;
      size_q     <= 3'd0;
      write_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (accept) begin
        idx_q   <= offset[AW+1:2];
        ofs_q   <= HADDR[1:0];
        size_q  <= HSIZE;
        write_q <= HWRITE;
      end
    end
  end

  ahb_byte_strobe_gen u_strobe (
    .hsize   (size_q),
    .addr_lo (ofs_q),
    .strobe  (strobe)
  );

  // Write lands at the edge ending the data phase, so an overlapped read sees it next cycle.
  always_ff @(posedge CLK) begin
    if (state_q == ST_DATA && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (strobe[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HRDATA = (state_q == ST_DATA && !write_q) ? mem[idx_q] : 32'd0;

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Directed bench for ahb_sram_subordinate: zero-wait and three-wait-state instances side by side.
module tb_ahb_sram_subordinate;

  logic        clk;
  logic        nrst    [2];
  logic        hsel    [2];
  logic [31:0] haddr   [2];
  logic [1:0]  htrans  [2];
  logic        hwrite  [2];
  logic [2:0]  hsize   [2];
  logic [31:0] hwdata  [2];
  logic        hready  [2];
  logic [31:0] hrdata  [2];
  logic        hreadyout [2];
  logic        hresp   [2];

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign hready[0] = hreadyout[0];
  assign hready[1] = hreadyout[1];

  ahb_sram_subordinate #(.WAIT_STATES(0)) dut0 (
    .CLK(clk), .nRST(nrst[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]), .HREADY(hready[0]),
    .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0])
  );

  ahb_sram_subordinate #(.WAIT_STATES(3)) dut3 (
    .CLK(clk), .nRST(nrst[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]), .HREADY(hready[1]),
    .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1])
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Single transfer followed by IDLE; reports data-phase wait cycles and response.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata, output int waits,
                      output logic resp_first, output logic resp_last);
    int guard;
    @(negedge clk);
    hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = addr; hwrite[d] = wr; hsize[d] = size;
    guard = 0;
    while (hreadyout[d] !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    hsel[d] = 1'b0; htrans[d] = 2'b00; hwdata[d] = wdata;
    waits = 0;
    resp_first = hresp[d];
    while (hreadyout[d] !== 1'b1 && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    rdata = hrdata[d];
    resp_last = hresp[d];
    if (guard >= 40 || waits >= 40) begin
      checks++;
      errors++;
      $display("FAIL timeout: dut%0d addr 0x%08h never completed", d, addr);
    end
  endtask

  vec_t vecs[15];
  logic [31:0] rd;
  logic        r1, r2;
  int          w;
  int          cyc;

  initial begin
    for (int d = 0; d < 2; d++) begin
      nrst[d] = 1'b0; hsel[d] = 1'b0; haddr[d] = 32'd0; htrans[d] = 2'b00;
      hwrite[d] = 1'b0; hsize[d] = 3'd0; hwdata[d] = 32'd0;
    end

    vecs[0]  = '{1'b1, 32'h8000_0010, 3'd2, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b0, 32'h8000_0010, 3'd2, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h8000_0010, 3'd2, 32'h1122_3344, 32'h0};
    vecs[3]  = '{1'b1, 32'h8000_0013, 3'd0, 32'hAA00_0000, 32'h0};
    vecs[4]  = '{1'b0, 32'h8000_0010, 3'd2, 32'h0,         32'hAA22_3344};
    vecs[5]  = '{1'b1, 32'h8000_0010, 3'd1, 32'h0000_5566, 32'h0};
    vecs[6]  = '{1'b0, 32'h8000_0010, 3'd2, 32'h0,         32'hAA22_5566};
    vecs[7]  = '{1'b1, 32'h8000_0014, 3'd2, 32'h0102_0304, 32'h0};
    vecs[8]  = '{1'b1, 32'h8000_0016, 3'd1, 32'hBEEF_0000, 32'h0};
    vecs[9]  = '{1'b0, 32'h8000_0014, 3'd2, 32'h0,         32'hBEEF_0304};
    vecs[10] = '{1'b1, 32'h8000_0017, 3'd0, 32'h7700_0000, 32'h0};
    vecs[11] = '{1'b0, 32'h8000_0015, 3'd2, 32'h0,         32'h77EF_0304};
    vecs[12] = '{1'b1, 32'h8000_0FFC, 3'd2, 32'hCAFE_F00D, 32'h0};
    vecs[13] = '{1'b1, 32'h8000_001B, 3'd2, 32'h1357_2468, 32'h0};
    vecs[14] = '{1'b0, 32'h8000_0018, 3'd2, 32'h0,         32'h1357_2468};

    #12;
    for (int d = 0; d < 2; d++) begin
      check32($sformatf("reset_hreadyout%0d", d), 32'(hreadyout[d]), 32'd1);
      check32($sformatf("reset_hresp%0d", d), 32'(hresp[d]), 32'd0);
      check32($sformatf("reset_hrdata%0d", d), hrdata[d], 32'd0);
    end
    @(negedge clk);
    nrst[0] = 1'b1; nrst[1] = 1'b1;

    // Zero-wait table: every data phase completes immediately with OKAY.
    for (int i = 0; i < 15; i++) begin
      xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, rd, w, r1, r2);
      check32($sformatf("vec%0d_waits", i), 32'(w), 32'd0);
      check32($sformatf("vec%0d_hresp", i), 32'(r2), 32'd0);
      if (!vecs[i].wr) begin
        exp_q.push_back(vecs[i].exp_rdata);
        check32($sformatf("vec%0d_rdata", i), rd, exp_q.pop_front());
      end
    end

    // Pipelined write then read of the same word, no idle between.
    @(negedge clk);
    hsel[0] = 1'b1; htrans[0] = 2'b10; haddr[0] = 32'h8000_0020; hwrite[0] = 1'b1; hsize[0] = 3'd2;
    @(negedge clk);
    check32("pipe_wr_ready", 32'(hreadyout[0]), 32'd1);
    hwdata[0] = 32'h600D_F00D; hwrite[0] = 1'b0;
    @(negedge clk);
    hsel[0] = 1'b0; htrans[0] = 2'b00;
    check32("pipe_rd_ready", 32'(hreadyout[0]), 32'd1);
    check32("pipe_rd_data", hrdata[0], 32'h600D_F00D);
    check32("pipe_rd_resp", 32'(hresp[0]), 32'd0);

`ifdef AHB_SRAM_ERR_RESP_EN
    xfer(0, 1'b0, 32'h7FFF_FFFC, 3'd2, 32'h0, rd, w, r1, r2);
    check32("err_waits", 32'(w), 32'd1);
    check32("err_resp1", 32'(r1), 32'd1);
    check32("err_resp2", 32'(r2), 32'd1);
    xfer(0, 1'b1, 32'h8000_0018, 3'd3, 32'hFFFF_FFFF, rd, w, r1, r2);
    check32("err_size_resp", 32'(r2), 32'd1);
    xfer(0, 1'b0, 32'h8000_0018, 3'd2, 32'h0, rd, w, r1, r2);
    check32("err_size_unchanged", rd, 32'h1357_2468);
    xfer(0, 1'b0, 32'h8000_0FFC, 3'd2, 32'h0, rd, w, r1, r2);
    check32("err_sram_unchanged", rd, 32'hCAFE_F00D);
`else
    xfer(0, 1'b0, 32'h7FFF_FFFC, 3'd2, 32'h0, rd, w, r1, r2);
    check32("wrap_waits", 32'(w), 32'd0);
    check32("wrap_resp", 32'(r2), 32'd0);
    check32("wrap_rdata", rd, 32'hCAFE_F00D);
    xfer(0, 1'b1, 32'h8000_0030, 3'd3, 32'h0F0F_0F0F, rd, w, r1, r2);
    xfer(0, 1'b0, 32'h8000_0030, 3'd2, 32'h0, rd, w, r1, r2);
    check32("size3_as_word", rd, 32'h0F0F_0F0F);
`endif

    // Three wait states: fill four words, then single read and SEQ burst.
    for (int k = 0; k < 4; k++) begin
      xfer(1, 1'b1, 32'h8000_0100 + 32'(4 * k), 3'd2, 32'hA5A5_0000 + 32'(k), rd, w, r1, r2);
      check32($sformatf("ws3_wr%0d_waits", k), 32'(w), 32'd3);
    end
    xfer(1, 1'b0, 32'h8000_0100, 3'd2, 32'h0, rd, w, r1, r2);
    check32("ws3_rd_waits", 32'(w), 32'd3);
    check32("ws3_rd_data", rd, 32'hA5A5_0000);

    @(negedge clk);
    hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h8000_0100; hwrite[1] = 1'b0; hsize[1] = 3'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k < 3) begin
        htrans[1] = 2'b11; haddr[1] = 32'h8000_0104 + 32'(4 * k);
      end else begin
        hsel[1] = 1'b0; htrans[1] = 2'b00;
      end
      cyc = 1;
      while (hreadyout[1] !== 1'b1 && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      check32($sformatf("burst%0d_cycles", k), 32'(cyc), 32'd4);
      check32($sformatf("burst%0d_data", k), hrdata[1], 32'hA5A5_0000 + 32'(k));
    end

    // Reset in the middle of a write's wait states must drop the write.
    xfer(1, 1'b1, 32'h8000_0040, 3'd2, 32'h0BAD_F00D, rd, w, r1, r2);
    @(negedge clk);
    hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h8000_0040; hwrite[1] = 1'b1; hsize[1] = 3'd2;
    @(negedge clk);
    hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 32'h1234_5678;
    check32("rst_wait_low", 32'(hreadyout[1]), 32'd0);
    #2 nrst[1] = 1'b0;
    #1;
    check32("rst_hreadyout", 32'(hreadyout[1]), 32'd1);
    check32("rst_hresp", 32'(hresp[1]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    nrst[1] = 1'b1;
    xfer(1, 1'b0, 32'h8000_0040, 3'd2, 32'h0, rd, w, r1, r2);
    check32("rst_old_data", rd, 32'h0BAD_F00D);
    check32("rst_read_waits", 32'(w), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
